// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of 32-bit IO ports. Each port has synchronized inputs,
// output and direction registers, sticky rising-edge flags and edge enables.
module mmio_port_bank #(
  parameter int          NUM_PORTS    = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFFFF00,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic [31:0]              writeData,
  input  logic [3:0]               byteEnable,
  input  logic                     writeEnable,
  input  logic                     readEnable,
  output logic [31:0]              readData,
  output logic                     readValid,
  output logic                     accessError,
  input  logic [32*NUM_PORTS-1:0]  portInputs,
  output logic [32*NUM_PORTS-1:0]  portOutputs,
  output logic [32*NUM_PORTS-1:0]  portDirections,
  output logic                     edgeInterrupt
);

  localparam logic [31:0] SPAN        = 32'(16 * NUM_PORTS);
  localparam logic [1:0]  REG_DATA    = 2'd0;
  localparam logic [1:0]  REG_DIR     = 2'd1;
  localparam logic [1:0]  REG_EDGE    = 2'd2;
  localparam logic [1:0]  REG_EDGE_EN = 2'd3;

  logic [31:0] outReg     [NUM_PORTS];
  logic [31:0] dirReg     [NUM_PORTS];
  logic [31:0] edgeFlags  [NUM_PORTS];
  logic [31:0] edgeEn     [NUM_PORTS];
  logic [31:0] edgeClear  [NUM_PORTS];
  logic [31:0] prevSynced [NUM_PORTS];
  logic [31:0] syncChain  [SYNC_STAGES][NUM_PORTS];

  logic [31:0] offset;
  logic [31:0] byteMask;
  logic [31:0] readMux;
  logic [3:0]  portSel;
  logic [1:0]  regSel;
  logic        hit;
  logic        aligned;
  logic        goodAccess;
  logic        writeHit;
  logic        anyPending;

  assign offset     = address - BASE_ADDRESS;
  assign hit        = (address >= BASE_ADDRESS) && (offset < SPAN);
  assign aligned    = (address[1:0] == 2'b00);
  assign goodAccess = hit && aligned;
  assign writeHit   = goodAccess && writeEnable;
  assign portSel    = offset[7:4];
  assign regSel     = offset[3:2];
  assign byteMask   = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                       {8{byteEnable[1]}}, {8{byteEnable[0]}}};

  // Read mux sees pre-write register contents, so a same-cycle write is invisible.
  always_comb begin
    readMux    = '0;
    anyPending = 1'b0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      edgeClear[n] = '0;
      if (portSel == 4'(n)) begin
        case (regSel)
          REG_DATA:    readMux = syncChain[SYNC_STAGES-1][n];
          REG_DIR:     readMux = dirReg[n];
          REG_EDGE:    readMux = edgeFlags[n];
          REG_EDGE_EN: readMux = edgeEn[n];
        endcase
        if (writeHit && (regSel == REG_EDGE))
          edgeClear[n] = writeData & byteMask;
      end
      if ((edgeFlags[n] & edgeEn[n]) != '0)
        anyPending = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readData      <= '0;
      readValid     <= 1'b0;
      accessError   <= 1'b0;
      edgeInterrupt <= 1'b0;
      for (int n = 0; n < NUM_PORTS; n++) begin
        outReg[n]     <= '0;
        dirReg[n]     <= '0;
        edgeFlags[n]  <= '0;
        edgeEn[n]     <= '0;
        prevSynced[n] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++)
          syncChain[s][n] <= '0;
      end
    end else begin
      readValid     <= goodAccess && readEnable;
      readData      <= (goodAccess && readEnable) ? readMux : '0;
      accessError   <= hit && !aligned && (readEnable || writeEnable);
      edgeInterrupt <= anyPending;
      for (int n = 0; n < NUM_PORTS; n++) begin
        syncChain[0][n] <= portInputs[32*n +: 32];
        for (int s = 1; s < SYNC_STAGES; s++)
          syncChain[s][n] <= syncChain[s-1][n];
        prevSynced[n] <= syncChain[SYNC_STAGES-1][n];
        // A new edge wins over a same-cycle clear of the same bit.
        edgeFlags[n] <= (edgeFlags[n] & ~edgeClear[n])
                      | (syncChain[SYNC_STAGES-1][n] & ~prevSynced[n]);
        if (writeHit && (portSel == 4'(n))) begin
          case (regSel)
            REG_DATA:    outReg[n] <= (outReg[n] & ~byteMask) | (writeData & byteMask);
            REG_DIR:     dirReg[n] <= (dirReg[n] & ~byteMask) | (writeData & byteMask);
            REG_EDGE_EN: edgeEn[n] <= (edgeEn[n] & ~byteMask) | (writeData & byteMask);
            default:     ;
          endcase
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : gPortOut
    assign portOutputs[32*n +: 32]    = outReg[n];
    assign portDirections[32*n +: 32] = dirReg[n];
  end

endmodule

// File: doc/mmio_port_bank.md
MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 Parameter NUM_PORTS, default 8, number of 32-bit IO ports, legal range 1..16.
REQ-002 Parameter BASE_ADDRESS, default 32'hFFFFFF00, byte address of port 0 register block, 256-byte aligned.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port address  input  32  byte address of bus access.
REQ-007 Port writeData  input  32  store data.
REQ-008 Port byteEnable  input  4  bit i enables data bits [8i+7:8i].
REQ-009 Port writeEnable  input  1  store strobe, one access per cycle.
REQ-010 Port readEnable  input  1  load strobe.
REQ-011 Port readData  output  32  load result.
REQ-012 Port readValid  output  1  readData valid this cycle.
REQ-013 Port accessError  output  1  one-cycle pulse on a bad access.
REQ-014 Port portInputs  input  32*NUM_PORTS  asynchronous external inputs; port n at [32n+31:32n].
REQ-015 Port portOutputs  output  32*NUM_PORTS  output data registers.
REQ-016 Port portDirections  output  32*NUM_PORTS  per-bit direction; 1 = drive output.
REQ-017 Port edgeInterrupt  output  1  OR of all edge flags masked by edge enables.

Function
REQ-018 Port n SHALL occupy 16 bytes at BASE_ADDRESS+16n: +0 DATA, +4 DIR, +8 EDGE, +C EDGE_EN.
REQ-019 An access SHALL hit only when address lies in [BASE_ADDRESS, BASE_ADDRESS+16*NUM_PORTS); non-hit accesses are ignored with no response.
REQ-020 Each portInputs bit SHALL pass through SYNC_STAGES flops before any use; DATA reads return the synchronized value, not the output register.
REQ-021 DATA write SHALL update portOutputs bytes selected by byteEnable; DIR and EDGE_EN writes likewise update their registers.
REQ-022 EDGE SHALL hold a sticky flag per bit, set when the synchronized bit was 0 last cycle and is 1 this cycle.
REQ-023 EDGE write SHALL be write-1-to-clear on enabled bytes; writing 0 leaves a flag unchanged.
REQ-024 Flag set and W1C clear on the same bit in the same cycle SHALL leave the flag set.
REQ-025 Reads SHALL have 1-cycle latency: readValid high and readData valid the cycle after a hit with readEnable; otherwise readValid 0 and readData 0.
REQ-026 A read returns the full 32-bit word regardless of byteEnable; reads SHALL have no side effects, including on EDGE.
REQ-027 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-028 A hit with address[1:0]!=0 SHALL be ignored, with accessError high for one cycle; for reads the pulse aligns with the would-be readValid cycle.
REQ-029 Both readEnable and writeEnable high on a hit SHALL perform both.
REQ-030 edgeInterrupt SHALL be registered: high the cycle after any (EDGE & EDGE_EN) bit is nonzero.

Reset
REQ-031 While reset is high, portOutputs, portDirections, EDGE, EDGE_EN, synchronizer flops, readData, readValid, accessError and edgeInterrupt SHALL all be 0.
REQ-032 The cycle reset is high SHALL NOT record an edge; first edge detection compares two post-reset synchronized samples.
REQ-033 A read issued in the cycle reset asserts SHALL produce no readValid.

Verification
REQ-034 NUM_PORTS=8: write 32'hDEADBEEF, byteEnable 4'b0101, to FFFFFF10 -> port 1 output = 32'h00AD00EF, other ports 0.
REQ-035 portInputs port 0 bit 3 rises -> DATA read at FFFFFF00 shows bit 3 no earlier than 2 cycles later; EDGE bit 3 set; with EDGE_EN bit 3 = 1, edgeInterrupt high 1 cycle after the flag.
REQ-036 Write 32'h8 to FFFFFF08 in the same cycle a new bit-3 edge arrives -> flag stays 1; a later write without an edge -> flag 0.
REQ-037 Read FFFFFF02 -> accessError pulse, readValid 0; read FFFFFF90 with NUM_PORTS=8 -> no response, no error.
REQ-038 Set DIR port 7 to FFFFFFFF, then assert reset for 1 cycle -> portDirections all 0 and EDGE cleared the following cycle.
REQ-039 Read and write DATA simultaneously -> readData is the synchronized input value; portOutputs updates one cycle later.
